// File: rtl/calc_simd_engine_pkg.sv
// Shared types for the SRAM calculator family: the original scalar FSM
// encoding plus the lane-wise SIMD engine's modes and states.
package calc_simd_engine_pkg;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_MEM_WORD_SIZE = 64;
  localparam int LANES             = DEF_MEM_WORD_SIZE / DEF_DATA_W;

  typedef enum logic [2:0] {
    CALC_IDLE   = 3'd0,
    CALC_READ_A = 3'd1,
    CALC_READ_B = 3'd2,
    CALC_EXEC   = 3'd3,
    CALC_WRITE  = 3'd4,
    CALC_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ADD_WRAP = 2'b00,
    SUB_WRAP = 2'b01,
    ADD_SAT  = 2'b10,
    SUB_SAT  = 2'b11
  } calc_mode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_WAIT_A = 3'd2,
    S_READ_B = 3'd3,
    S_WAIT_B = 3'd4,
    S_EXEC   = 3'd5,
    S_WRITE  = 3'd6,
    S_END    = 3'd7
  } simd_state_t;

  function automatic int calc_lanes(input int mem_w, input int data_w);
    return mem_w / data_w;
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One independent lane: add/sub in wrap or unsigned-saturate form, with the
// carry/borrow reported separately so lanes never couple.
module simd_lane_alu
  import calc_simd_engine_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  calc_mode_t        i_mode,
  output logic [DATA_W-1:0] o_res,
  output logic              o_ovf
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Select result and flag; the top bit of the extended sum/diff is carry/borrow.
  always_comb begin
    o_res = w_sum[DATA_W-1:0];
    o_ovf = 1'b0;
    case (i_mode)
      ADD_WRAP: begin
        o_res = w_sum[DATA_W-1:0];
        o_ovf = w_sum[DATA_W];
      end
      SUB_WRAP: begin
        o_res = w_diff[DATA_W-1:0];
        o_ovf = w_diff[DATA_W];
      end
      ADD_SAT: begin
        o_res = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
        o_ovf = w_sum[DATA_W];
      end
      SUB_SAT: begin
        o_res = w_diff[DATA_W] ? {DATA_W{1'b0}} : w_diff[DATA_W-1:0];
        o_ovf = w_diff[DATA_W];
      end
      default: begin
        o_res = {DATA_W{1'b0}};
        o_ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_simd_engine.sv
// Streams COUNT operand pairs from a single-port SRAM, applies a lane-wise
// add/sub, and writes each result word back; start/done handshake to the controller.
module calc_simd_engine
  import calc_simd_engine_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 9,
  parameter int RD_LAT        = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [1:0]               i_mode,
  input  logic [ADDR_W-1:0]        i_src_a_addr,
  input  logic [ADDR_W-1:0]        i_src_b_addr,
  input  logic [ADDR_W-1:0]        i_dst_addr,
  input  logic [ADDR_W:0]          i_count,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overflow,
  output logic                     o_mem_read_en,
  output logic                     o_mem_write_en,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [MEM_WORD_SIZE-1:0] o_mem_wdata,
  input  logic [MEM_WORD_SIZE-1:0] i_mem_rdata
);

  localparam int NLANES = calc_lanes(MEM_WORD_SIZE, DATA_W);
  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  simd_state_t              r_state;
  calc_mode_t               r_mode;
  logic [ADDR_W-1:0]        r_src_a;
  logic [ADDR_W-1:0]        r_src_b;
  logic [ADDR_W-1:0]        r_dst;
  logic [ADDR_W:0]          r_count;
  logic [ADDR_W:0]          r_idx;
  logic [2:0]               r_wait;
  logic [MEM_WORD_SIZE-1:0] r_opa;
  logic [MEM_WORD_SIZE-1:0] r_opb;
  logic [MEM_WORD_SIZE-1:0] r_res;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_ovf;
  logic                     r_rd_en;
  logic                     r_wr_en;
  logic [ADDR_W-1:0]        r_addr;

  logic [MEM_WORD_SIZE-1:0] w_res;
  logic [NLANES-1:0]        w_ovf;
  logic [ADDR_W:0]          w_idx_nxt;
  logic [ADDR_W-1:0]        w_b_addr;
  logic [ADDR_W-1:0]        w_d_addr;
  logic [ADDR_W-1:0]        w_a_nxt_addr;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    simd_lane_alu #(.DATA_W(DATA_W)) u_alu (
      .i_a    (r_opa[k*DATA_W +: DATA_W]),
      .i_b    (r_opb[k*DATA_W +: DATA_W]),
      .i_mode (r_mode),
      .o_res  (w_res[k*DATA_W +: DATA_W]),
      .o_ovf  (w_ovf[k])
    );
  end

  // Address sums truncate to ADDR_W, so blocks wrap past the last line.
  assign w_idx_nxt    = r_idx + (ADDR_W+1)'(1);
  assign w_b_addr     = r_src_b + r_idx[ADDR_W-1:0];
  assign w_d_addr     = r_dst + r_idx[ADDR_W-1:0];
  assign w_a_nxt_addr = r_src_a + w_idx_nxt[ADDR_W-1:0];

  // Sequencer: every output is a register set on the transition into its state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= ADD_WRAP;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_wait  <= 3'd0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode  <= calc_mode_t'(i_mode);
            r_src_a <= i_src_a_addr;
            r_src_b <= i_src_b_addr;
            r_dst   <= i_dst_addr;
            r_count <= i_count;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            if (i_count == '0) begin
              r_state <= S_END;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ_A;
              r_rd_en <= 1'b1;
              r_addr  <= i_src_a_addr;
            end
          end
        end
        S_READ_A: begin
          r_rd_en <= 1'b0;
          r_wait  <= 3'd0;
          r_state <= S_WAIT_A;
        end
        S_WAIT_A: begin
          if (r_wait == WAIT_LAST) begin
            r_opa   <= i_mem_rdata;
            r_state <= S_READ_B;
            r_rd_en <= 1'b1;
            r_addr  <= w_b_addr;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_READ_B: begin
          r_rd_en <= 1'b0;
          r_wait  <= 3'd0;
          r_state <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (r_wait == WAIT_LAST) begin
            r_opb   <= i_mem_rdata;
            r_state <= S_EXEC;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_EXEC: begin
          r_res   <= w_res;
          r_ovf   <= r_ovf | (|w_ovf);
          r_state <= S_WRITE;
          r_wr_en <= 1'b1;
          r_addr  <= w_d_addr;
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
          r_idx   <= w_idx_nxt;
          if (w_idx_nxt == r_count) begin
            r_state <= S_END;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_READ_A;
            r_rd_en <= 1'b1;
            r_addr  <= w_a_nxt_addr;
          end
        end
        S_END: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_overflow     = r_ovf;
  assign o_mem_read_en  = r_rd_en;
  assign o_mem_write_en = r_wr_en;
  assign o_mem_addr     = r_addr;
  assign o_mem_wdata    = r_res;

endmodule

// File: tb/tb_calc_simd_engine.sv
// Bench for calc_simd_engine: an SRAM model plus a cycle-schedule model of each
// run, checked every cycle, with hand-computed literals pinning the model.
module tb_calc_simd_engine;

  localparam int DW = 32;
  localparam int MW = 64;
  localparam int AW = 9;
  localparam int LN = MW / DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start1 = 1'b0, start3 = 1'b0, sel3 = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] sa = '0, sb = '0, sd = '0;
  logic [AW:0]   cnt = '0;

  logic          busy1, done1, ovf1, rd1, wr1, busy3, done3, ovf3, rd3, wr3;
  logic [AW-1:0] addr1, addr3;
  logic [MW-1:0] wdata1, wdata3, rdata1, rdata3;

  calc_simd_engine #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_mode(mode),
    .i_src_a_addr(sa), .i_src_b_addr(sb), .i_dst_addr(sd), .i_count(cnt),
    .o_busy(busy1), .o_done(done1), .o_overflow(ovf1),
    .o_mem_read_en(rd1), .o_mem_write_en(wr1), .o_mem_addr(addr1),
    .o_mem_wdata(wdata1), .i_mem_rdata(rdata1));

  calc_simd_engine #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_mode(mode),
    .i_src_a_addr(sa), .i_src_b_addr(sb), .i_dst_addr(sd), .i_count(cnt),
    .o_busy(busy3), .o_done(done3), .o_overflow(ovf3),
    .o_mem_read_en(rd3), .o_mem_write_en(wr3), .o_mem_addr(addr3),
    .o_mem_wdata(wdata3), .i_mem_rdata(rdata3));

  // The idle engine keeps its strobes low, so the SRAM sees the selected one.
  logic          m_busy, m_done, m_ovf, m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [MW-1:0] m_wdata;
  assign m_busy  = sel3 ? busy3  : busy1;
  assign m_done  = sel3 ? done3  : done1;
  assign m_ovf   = sel3 ? ovf3   : ovf1;
  assign m_rd    = rd1 | rd3;
  assign m_wr    = wr1 | wr3;
  assign m_addr  = sel3 ? addr3  : addr1;
  assign m_wdata = sel3 ? wdata3 : wdata1;

  logic [MW-1:0] mem [512];
  logic [MW-1:0] pipe [4];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [MW-1:0] poke_data = '0;

  always @(posedge clk) begin
    if (m_wr) mem[m_addr] <= m_wdata;
    else if (poke_en) mem[poke_addr] <= poke_data;
    pipe[0] <= m_rd ? mem[m_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
  end
  assign rdata1 = pipe[0];
  assign rdata3 = pipe[2];

  int edge_n = 0, wcount = 0, dcount = 0, last_done = 0;
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(negedge clk) begin
    if (m_wr) wcount <= wcount + 1;
    if (m_done) begin
      dcount    <= dcount + 1;
      last_done <= edge_n;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int t0 = 0, run_len = 0, run_d = 0, run_n = 0;
  bit active = 1'b0;

  logic [MW-1:0] mm [512];
  bit            exp_rd [64], exp_wr [64], exp_busy [64], exp_done [64], exp_ovf [64];
  logic [AW-1:0] exp_addr [64];
  logic [MW-1:0] exp_wdata [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Lane-wise reference using plain unsigned arithmetic on 64-bit integers.
  function automatic void word_op(input logic [1:0] md, input logic [MW-1:0] x, input logic [MW-1:0] y,
                                  output logic [MW-1:0] r, output bit o);
    longint unsigned xa, yb, s;
    o = 1'b0;
    r = '0;
    for (int k = 0; k < LN; k++) begin
      xa = {32'd0, x[DW*k +: DW]};
      yb = {32'd0, y[DW*k +: DW]};
      if (md[0] == 1'b0) begin
        s = xa + yb;
        if (s > 64'hFFFF_FFFF) begin
          o = 1'b1;
          s = md[1] ? 64'hFFFF_FFFF : s - 64'h1_0000_0000;
        end
      end else if (yb > xa) begin
        o = 1'b1;
        s = md[1] ? 64'd0 : xa + 64'h1_0000_0000 - yb;
      end else begin
        s = xa - yb;
      end
      r[DW*k +: DW] = s[DW-1:0];
    end
  endfunction

  // Expected per-cycle outputs: element e occupies cycles 1+e*P .. (e+1)*P.
  task automatic plan(input int lat, input logic [1:0] md, input int a, input int b, input int d, input int n);
    int p, base, wc, ovf_c;
    logic [MW-1:0] r;
    bit o;
    p = 4 + 2*lat;
    run_len = p*n + 1;
    run_d = d;
    run_n = n;
    ovf_c = 0;
    for (int c = 0; c < 64; c++) begin
      exp_rd[c] = 1'b0; exp_wr[c] = 1'b0; exp_done[c] = 1'b0;
      exp_busy[c] = (c >= 1 && c <= run_len);
      exp_addr[c] = '0; exp_wdata[c] = '0;
    end
    exp_done[run_len] = 1'b1;
    for (int e = 0; e < n; e++) begin
      base = 1 + e*p;
      exp_rd[base] = 1'b1;
      exp_addr[base] = AW'((a + e) % 512);
      exp_rd[base+1+lat] = 1'b1;
      exp_addr[base+1+lat] = AW'((b + e) % 512);
      wc = base + p - 1;
      exp_wr[wc] = 1'b1;
      exp_addr[wc] = AW'((d + e) % 512);
      word_op(md, mm[(a+e)%512], mm[(b+e)%512], r, o);
      exp_wdata[wc] = r;
      mm[(d+e)%512] = r;
      if (o && ovf_c == 0) ovf_c = wc;
    end
    for (int c = 0; c < 64; c++) exp_ovf[c] = (ovf_c != 0 && c >= ovf_c);
  endtask

  // Per-cycle comparison against the schedule while a run is being tracked.
  always @(negedge clk) begin
    int rel;
    rel = edge_n - t0;
    if (active && rel >= 1 && rel < 64) begin
      chk("busy", 64'(m_busy), 64'(exp_busy[rel]));
      chk("done", 64'(m_done), 64'(exp_done[rel]));
      chk("overflow", 64'(m_ovf), 64'(exp_ovf[rel]));
      chk("mem_read_en", 64'(m_rd), 64'(exp_rd[rel]));
      chk("mem_write_en", 64'(m_wr), 64'(exp_wr[rel]));
      if (exp_rd[rel] || exp_wr[rel]) chk("mem_addr", 64'(m_addr), 64'(exp_addr[rel]));
      if (exp_wr[rel]) chk("mem_wdata", m_wdata, exp_wdata[rel]);
    end
  end

  task automatic poke(input int a, input logic [MW-1:0] v);
    @(posedge clk); #2;
    poke_en = 1'b1; poke_addr = AW'(a); poke_data = v; mm[a] = v;
    @(posedge clk); #2;
    poke_en = 1'b0;
  endtask

  task automatic run(input int lat, input logic [1:0] md, input int a, input int b, input int d, input int n);
    plan(lat, md, a, b, d, n);
    @(posedge clk); #2;
    sel3 = (lat == 3);
    mode = md; sa = AW'(a); sb = AW'(b); sd = AW'(d); cnt = (AW+1)'(n);
    if (lat == 3) start3 = 1'b1;
    else start1 = 1'b1;
    t0 = edge_n;
    active = 1'b1;
    @(posedge clk); #2;
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic finish_run(output int done_cyc);
    while (edge_n - t0 < run_len + 3) @(posedge clk);
    #2;
    active = 1'b0;
    done_cyc = last_done - t0;
    for (int e = 0; e < run_n; e++) chk("mem_result", mem[(run_d+e)%512], mm[(run_d+e)%512]);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(m_busy), 64'd0);
    chk({tag, "_done"}, 64'(m_done), 64'd0);
    chk({tag, "_ovf"}, 64'(m_ovf), 64'd0);
    chk({tag, "_rd"}, 64'(m_rd), 64'd0);
    chk({tag, "_wr"}, 64'(m_wr), 64'd0);
    chk({tag, "_addr"}, 64'(m_addr), 64'd0);
    chk({tag, "_wdata"}, m_wdata, 64'd0);
  endtask

  initial begin
    int dc, w0, d0;
    for (int k = 0; k < 512; k++) mm[k] = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_idle("reset1");
    sel3 = 1'b1; #1;
    chk_idle("reset3");
    sel3 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // add-wrap, carry out of lane 0 must not reach lane 1
    poke(10, 64'h00000001_FFFFFFFF);
    poke(20, 64'h00000001_00000001);
    run(1, 2'b00, 10, 20, 30, 1);
    finish_run(dc);
    chk("t1_result", mem[30], 64'h00000002_00000000);
    chk("t1_ovf", 64'(ovf1), 64'd1);
    chk("t1_done_cycle", 64'(dc), 64'd7);

    run(1, 2'b10, 10, 20, 31, 1);
    finish_run(dc);
    chk("addsat_result", mem[31], 64'h00000002_FFFFFFFF);
    chk("addsat_ovf", 64'(ovf1), 64'd1);

    poke(11, 64'h00000005_00000003);
    poke(21, 64'h00000003_00000005);
    run(1, 2'b11, 11, 21, 32, 1);
    finish_run(dc);
    chk("subsat_result", mem[32], 64'h00000002_00000000);
    chk("subsat_ovf", 64'(ovf1), 64'd1);

    // source block wraps past line 511
    poke(510, 64'h00000001_00000002); poke(511, 64'h7FFFFFFF_80000000);
    poke(0, 64'hFFFFFFFF_00000000);   poke(1, 64'h12345678_9ABCDEF0);
    poke(100, 64'h00000003_00000004); poke(101, 64'h00000001_80000000);
    poke(102, 64'h00000001_00000001); poke(103, 64'h11111111_11111111);
    run(1, 2'b00, 510, 100, 200, 4);
    finish_run(dc);
    chk("wrap_done_cycle", 64'(dc), 64'd25);
    chk("wrap_elem1", mem[201], 64'h80000000_00000000);
    chk("wrap_elem2", mem[202], 64'h00000000_00000001);

    w0 = wcount;
    run(1, 2'b00, 0, 0, 0, 0);
    finish_run(dc);
    chk("count0_done_cycle", 64'(dc), 64'd1);
    chk("count0_ovf", 64'(ovf1), 64'd0);
    chk("count0_writes", 64'(wcount - w0), 64'd0);

    // start pulsed mid-run with different inputs must be ignored
    poke(300, 64'hFFFFFFF0_00000010); poke(310, 64'h00000020_00000005);
    poke(301, 64'h00000001_00000001); poke(311, 64'h00000002_00000002);
    poke(302, 64'h80000000_7FFFFFFF); poke(312, 64'h7FFFFFFF_00000001);
    w0 = wcount;
    run(1, 2'b10, 300, 310, 320, 3);
    repeat (4) @(posedge clk);
    #2;
    start1 = 1'b1; mode = 2'b11; sa = AW'(0); sd = AW'(5); cnt = (AW+1)'(1);
    @(posedge clk); #2;
    start1 = 1'b0;
    finish_run(dc);
    chk("busy_start_writes", 64'(wcount - w0), 64'd3);
    chk("busy_start_elem0", mem[320], 64'hFFFFFFFF_00000015);
    chk("busy_start_done_cycle", 64'(dc), 64'd19);

    // reset during WAIT_B of element 2 (cycle 16)
    poke(50, 64'h00000010_00000020); poke(60, 64'h00000001_00000002);
    poke(51, 64'h1); poke(61, 64'h2); poke(52, 64'h3); poke(62, 64'h4);
    poke(53, 64'h5); poke(63, 64'h6);
    poke(72, 64'hA5A5A5A5_A5A5A5A5);
    w0 = wcount; d0 = dcount;
    run(1, 2'b00, 50, 60, 70, 4);
    while (edge_n - t0 < 16) @(posedge clk);
    #2;
    active = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle("abort");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("abort_writes", 64'(wcount - w0), 64'd2);
    chk("abort_no_done", 64'(dcount - d0), 64'd0);
    chk("abort_elem2", mem[72], 64'hA5A5A5A5_A5A5A5A5);

    run(1, 2'b01, 50, 60, 80, 1);
    finish_run(dc);
    chk("subwrap_result", mem[80], 64'h0000000F_0000001E);
    chk("subwrap_ovf", 64'(ovf1), 64'd0);
    chk("subwrap_done_cycle", 64'(dc), 64'd7);

    // RD_LAT=3, in place on the A block
    poke(16, 64'h00000001_00000002); poke(17, 64'h00000010_00000020);
    poke(40, 64'h00000003_00000004); poke(41, 64'h00000030_00000040);
    run(3, 2'b00, 16, 40, 16, 2);
    finish_run(dc);
    chk("lat3_done_cycle", 64'(dc), 64'd21);
    chk("lat3_line16", mem[16], 64'h00000004_00000006);
    chk("lat3_line17", mem[17], 64'h00000040_00000060);
    chk("lat3_ovf", 64'(ovf3), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_simd_engine.md
Name: calc_simd_engine

Overview:
- Parametrised successor to the single-operand-pair SRAM calculator.
- Streams a block of COUNT element pairs from SRAM, applies a selectable lane-wise operation, and writes the results back to SRAM.
- Each memory word is split into LANES independent DATA_W lanes. Supported operations are add or sub, each in wrap or unsigned-saturate form.
- Sits between the top-level controller (start/done handshake) and the single-port operand SRAM.

Parameters:
- DATA_W, 32, lane width in bits.
- MEM_WORD_SIZE, 64, SRAM word width. Must be an integer multiple of DATA_W; LANES = MEM_WORD_SIZE/DATA_W.
- ADDR_W, 9, SRAM address width (512 lines).
- RD_LAT, 1, SRAM read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run. Sampled only in IDLE.
- mode  in  2  00 add-wrap, 01 sub-wrap, 10 add-sat (unsigned), 11 sub-sat (unsigned). Latched at start.
- src_a_addr  in  ADDR_W  base address of the A operand block. Latched at start.
- src_b_addr  in  ADDR_W  base address of the B operand block. Latched at start.
- dst_addr  in  ADDR_W  base address of the result block. Latched at start.
- count  in  ADDR_W+1  number of elements, 0..512. Latched at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- overflow  out  1  sticky: any lane carry or borrow during the run. Cleared at the next accepted start.
- mem_read_en  out  1  SRAM read strobe.
- mem_write_en  out  1  SRAM write strobe.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  MEM_WORD_SIZE  SRAM write data.
- mem_rdata  in  MEM_WORD_SIZE  SRAM read data, valid RD_LAT cycles after a read_en cycle.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0, including mem_addr and mem_wdata.
  - Internal index, wait counter, operand and result registers = 0.
- Reset asserted mid-run aborts immediately. No further SRAM access occurs and done is not pulsed.
- State machine: IDLE, READ_A, WAIT_A, READ_B, WAIT_B, EXEC, WRITE, END.
- IDLE:
  - start=1 latches mode, addresses and count; clears overflow; sets index i=0.
  - Next state is READ_A, or END if count==0.
  - start while busy is ignored with no effect.
- READ_A: mem_read_en=1, mem_addr = src_a_addr+i. Next state WAIT_A.
- WAIT_A: stays RD_LAT cycles. Captures mem_rdata into opa on the final wait cycle. Next state READ_B.
- READ_B: mem_read_en=1, mem_addr = src_b_addr+i. Next state WAIT_B.
- WAIT_B: same as WAIT_A, capturing into opb. Next state EXEC.
- EXEC:
  - Per lane k (bits k*DATA_W +: DATA_W), computes res_k from opa_k and opb_k and registers it.
  - Sets overflow if any lane produced a carry-out (add) or borrow (sub).
  - Wrap modes: result is modulo 2^DATA_W.
  - Sat modes: add clamps to all-ones; sub clamps to 0.
  - Lanes never propagate carry into one another.
- WRITE: mem_write_en=1, mem_addr = dst_addr+i, mem_wdata = registered result. Then i increments. Next state END if i+1==count, else READ_A.
- END: done=1 for exactly one cycle. Next state IDLE.
- Address arithmetic is modulo 2^ADDR_W, so a block crossing line 511 wraps to line 0.
- Overlap of the destination with a source block is legal. Element i's write happens after element i's reads, so in-place operation (dst==src_a) is safe.
- mem_read_en and mem_write_en are never high in the same cycle. mem_addr is don't-care when both are low, but holds its last value.
- Latency:
  - 4+2*RD_LAT cycles per element (6 at default).
  - done is high in cycle (4+2*RD_LAT)*count+1 after the start edge.
  - count=0 gives done in cycle 1.
- overflow stays valid after done until the next accepted start.

Decomposition:
- The shared calculator package gains:
  - LANES derived constant.
  - calc_mode_t enum: ADD_WRAP, SUB_WRAP, ADD_SAT, SUB_SAT.
  - simd_state_t enum with the eight states above.
  - The existing state_t is left untouched for the original block.
- One sub-module: simd_lane_alu. It is combinational, parameterised by DATA_W, and takes (a, b, mode) and returns (res, ovf). The engine instantiates it LANES times in a generate loop.

Test Plan:
- mode=00, count=1, A[0]=64'h00000001_FFFFFFFF, B[0]=64'h00000001_00000001 -> dst[0]=64'h00000002_00000000, overflow=1, done pulse in cycle 7.
- mode=10, same operands -> dst[0]=64'h00000002_FFFFFFFF, overflow=1. mode=11 with A=64'h5_3, B=64'h3_5 -> dst=64'h2_0, overflow=1.
- count=4, src_a=510, src_b=100, dst=200 -> reads wrap to lines 510,511,0,1; four writes at 200..203; done in cycle 25; busy high from cycles 1 through 25.
- count=0 -> no mem_read_en or mem_write_en, done in cycle 1, overflow=0. A second start pulsed while busy during a count=3 run -> ignored, exactly 3 writes.
- Reset asserted during WAIT_B of element 2 -> all outputs 0 immediately, no write to element 2, no done. A fresh start then runs cleanly.
- RD_LAT=3, count=2, in-place (dst=src_a=16) -> 10 cycles per element, done in cycle 21, lines 16 and 17 hold the sums.
